// File: rtl/trace_capture.sv
// Instruction trace capture: records {pc, result} on PC change into a
// first-word-fall-through FIFO with saturating overflow drop counter.
module trace_capture #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [W-1:0]           pc_in,
    input  logic [W-1:0]           result_in,
    input  logic                   en,
    output logic [2*W-1:0]         trc_data,
    output logic                   trc_valid,
    input  logic                   trc_ready,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [7:0]             drop_cnt
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ARMED, TRACK} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [W-1:0]     r_last_pc;
    logic [2*W-1:0]   r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW:0]      r_count;
    logic [7:0]       r_drop;
    logic             w_cap;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;

    always_comb begin
        w_next = r_state;
        w_cap  = 1'b0;
        case (r_state)
            IDLE: begin
                if (en) w_next = ARMED;
            end
            ARMED: begin
                if (en) begin
                    w_next = TRACK;
                    w_cap  = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            TRACK: begin
                if (!en) w_next = IDLE;
                else     w_cap  = (pc_in != r_last_pc);
            end
            default: w_next = IDLE;
        endcase
    end

    assign empty     = (r_count == '0);
    assign full      = (r_count == (AW+1)'(DEPTH));
    assign trc_valid = !empty;
    assign count     = r_count;
    assign drop_cnt  = r_drop;
    assign trc_data  = empty ? '0 : r_mem[r_rd_ptr];

    // A full FIFO still accepts a capture when the head leaves on the same edge.
    assign w_pop  = trc_valid && trc_ready;
    assign w_push = w_cap && (!full || w_pop);
    assign w_drop = w_cap && full && !w_pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_last_pc <= '0;
        end else begin
            r_state <= w_next;
            if (w_cap) r_last_pc <= pc_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_drop   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {pc_in, result_in};
    end

endmodule

// File: tb/tb_trace_capture.sv
// Bench for trace_capture: scenario tasks checked against a queue-based
// model of the capture rules and FIFO behaviour.
module tb_trace_capture;

    logic        clk;
    logic        reset;
    logic [7:0]  t_pc;
    logic [7:0]  t_res;
    logic        t_en;
    logic        t_rdy;
    logic [15:0] trc_data;
    logic        trc_valid;
    logic        full;
    logic        empty;
    logic [3:0]  count;
    logic [7:0]  drop_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    trace_capture #(.DEPTH(8), .W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .pc_in     (t_pc),
        .result_in (t_res),
        .en        (t_en),
        .trc_data  (trc_data),
        .trc_valid (trc_valid),
        .trc_ready (t_rdy),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [30:0] obs = {trc_valid, full, empty, count, drop_cnt, trc_data};

    // model: 0 = disabled, 1 = just enabled, 2 = following PC changes
    logic [15:0] q[$];
    int          m_mode;
    logic [7:0]  m_last;
    int          m_drop;

    function automatic void model_reset();
        q.delete();
        m_mode = 0;
        m_last = 8'h00;
        m_drop = 0;
    endfunction

    function automatic void model_edge();
        bit pop;
        bit cap;
        pop = (q.size() > 0) && t_rdy;
        cap = t_en && (m_mode == 1 || (m_mode == 2 && t_pc != m_last));
        if (cap) m_last = t_pc;
        if (pop) void'(q.pop_front());
        if (cap) begin
            if (q.size() < 8) q.push_back({t_pc, t_res});
            else if (m_drop < 255) m_drop++;
        end
        if (!t_en)            m_mode = 0;
        else if (m_mode == 0) m_mode = 1;
        else                  m_mode = 2;
    endfunction

    function automatic logic [30:0] exp_obs();
        logic [15:0] d;
        d = (q.size() > 0) ? q[0] : 16'h0000;
        return {1'(q.size() > 0), 1'(q.size() == 8), 1'(q.size() == 0),
                4'(q.size()), 8'(m_drop), d};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!reset) model_reset();
        else        model_edge();
        #1;
    endtask

    task automatic do_reset();
        t_en  = 1'b0;
        t_rdy = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        n_checks++;
        if (obs !== {3'b001, 28'h0})
            $display("FAIL reset_state: got %h want %h", obs, {3'b001, 28'h0});
        else n_pass++;
        n_checks++;
        if (obs !== exp_obs())
            $display("FAIL reset_model: got %h want %h", obs, exp_obs());
        else n_pass++;
        reset = 1'b1;
    endtask

    task automatic test_const_pc();
        do_reset();
        t_en = 1'b1; t_pc = 8'h00; t_res = 8'h11;
        tick();
        n_checks++;
        if (trc_valid !== 1'b0)
            $display("FAIL const_armed_valid: got %b want 0", trc_valid);
        else n_pass++;
        tick();
        n_checks++;
        if (trc_valid !== 1'b1 || trc_data !== 16'h0011)
            $display("FAIL const_first: got %b/%h want 1/0011", trc_valid, trc_data);
        else n_pass++;
        repeat (4) tick();
        n_checks++;
        if (count !== 4'd1 || obs !== exp_obs())
            $display("FAIL const_single: got %h want %h", obs, exp_obs());
        else n_pass++;
    endtask

    task automatic test_pc_step();
        logic [15:0] got[$];
        int          maxc;
        maxc = 0;
        do_reset();
        t_rdy = 1'b1; t_en = 1'b1; t_pc = 8'h00; t_res = 8'hA0;
        tick();
        for (int i = 0; i < 3; i++) begin
            t_pc  = 8'(i);
            t_res = 8'(8'hA0 + i);
            if (trc_valid) got.push_back(trc_data);
            tick();
            if (int'(count) > maxc) maxc = int'(count);
            n_checks++;
            if (trc_valid !== 1'b1 || obs !== exp_obs())
                $display("FAIL step_cycle%0d: got %h want %h", i, obs, exp_obs());
            else n_pass++;
        end
        t_en = 1'b0;
        if (trc_valid) got.push_back(trc_data);
        tick();
        n_checks++;
        if (got.size() != 3 || got[0] !== 16'h00A0 || got[1] !== 16'h01A1 || got[2] !== 16'h02A2)
            $display("FAIL step_order: got %p want 00a0 01a1 02a2", got);
        else n_pass++;
        n_checks++;
        if (maxc > 1 || empty !== 1'b1)
            $display("FAIL step_maxcount: got %0d/%b want <=1/1", maxc, empty);
        else n_pass++;
    endtask

    task automatic fill_overflow();
        do_reset();
        t_en = 1'b1; t_pc = 8'h00; t_res = 8'h00;
        tick();
        for (int i = 0; i < 10; i++) begin
            t_pc  = 8'(i * 3 + 1);
            t_res = 8'(8'h40 + i);
            tick();
        end
    endtask

    task automatic test_overflow_pushpop();
        fill_overflow();
        n_checks++;
        if (full !== 1'b1 || count !== 4'd8 || drop_cnt !== 8'd2)
            $display("FAIL ovf_state: got %b/%0d/%0d want 1/8/2", full, count, drop_cnt);
        else n_pass++;
        n_checks++;
        if (trc_data !== 16'h0140)
            $display("FAIL ovf_head: got %h want 0140", trc_data);
        else n_pass++;
        t_pc = 8'h77; t_res = 8'h99; t_rdy = 1'b1;
        tick();
        n_checks++;
        if (count !== 4'd8 || drop_cnt !== 8'd2 || obs !== exp_obs())
            $display("FAIL full_pushpop: got %h want %h", obs, exp_obs());
        else n_pass++;
        t_en = 1'b0;
        for (int i = 1; i < 9; i++) begin
            logic [15:0] want;
            want = (i < 8) ? {8'(i * 3 + 1), 8'(8'h40 + i)} : 16'h7799;
            n_checks++;
            if (trc_data !== want)
                $display("FAIL drain_%0d: got %h want %h", i, trc_data, want);
            else n_pass++;
            tick();
        end
        n_checks++;
        if (empty !== 1'b1 || drop_cnt !== 8'd2)
            $display("FAIL drain_end: got %b/%0d want 1/2", empty, drop_cnt);
        else n_pass++;
    endtask

    task automatic test_rearm();
        do_reset();
        t_en = 1'b1; t_pc = 8'h05; t_res = 8'h31;
        tick();
        tick();
        tick();
        t_en = 1'b0;
        tick();
        t_en = 1'b1; t_res = 8'h32;
        tick();
        tick();
        n_checks++;
        if (count !== 4'd2 || obs !== exp_obs())
            $display("FAIL rearm_count: got %h want %h", obs, exp_obs());
        else n_pass++;
        t_en = 1'b0; t_rdy = 1'b1;
        tick();
        n_checks++;
        if (trc_data !== 16'h0532)
            $display("FAIL rearm_second: got %h want 0532", trc_data);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        fill_overflow();
        t_en = 1'b0; t_rdy = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (count !== 4'd5 || drop_cnt !== 8'd2)
            $display("FAIL mid_pre: got %0d/%0d want 5/2", count, drop_cnt);
        else n_pass++;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (trc_valid !== 1'b0 || count !== 4'd0 || drop_cnt !== 8'd0 || obs !== exp_obs())
            $display("FAIL mid_async: got %h want %h", obs, exp_obs());
        else n_pass++;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_drop_sat();
        do_reset();
        t_en = 1'b1; t_pc = 8'h00; t_res = 8'h5A;
        tick();
        for (int i = 0; i < 270; i++) begin
            t_pc = 8'(i & 1) + 8'h10;
            tick();
        end
        n_checks++;
        if (drop_cnt !== 8'd255 || obs !== exp_obs())
            $display("FAIL drop_sat: got %h want %h", obs, exp_obs());
        else n_pass++;
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            t_en  = ($urandom_range(0, 7) != 0);
            t_pc  = 8'($urandom_range(0, 3));
            t_res = 8'($urandom);
            t_rdy = (i < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
            tick();
            n_checks++;
            if (obs !== exp_obs()) begin
                if (bad < 10)
                    $display("FAIL random_%0d: got %h want %h", i, obs, exp_obs());
                bad++;
            end else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b0;
        t_en  = 1'b0;
        t_pc  = 8'h00;
        t_res = 8'h00;
        t_rdy = 1'b0;
        model_reset();
        test_reset();
        test_const_pc();
        test_pc_step();
        test_overflow_pushpop();
        test_rearm();
        test_reset_mid();
        test_drop_sat();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/trace_capture.md
TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entry count; SHALL be a power of two, 2..64.
REQ-002 Parameter W, default 8, width of PC and result fields.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; low SHALL force reset state immediately, independent of clk.
REQ-005 pc_in  input  W  processor program counter (the core's pc_out).
REQ-006 result_in  input  W  processor result bus (the core's result_out).
REQ-007 en  input  1  capture enable.
REQ-008 trc_data  output  2*W  head entry, {pc[W-1:0], result[W-1:0]}, PC in the upper half.
REQ-009 trc_valid  output  1  head entry present.
REQ-010 trc_ready  input  1  consumer accepts the head entry.
REQ-011 full  output  1  count == DEPTH.
REQ-012 empty  output  1  count == 0.
REQ-013 count  output  log2(DEPTH)+1  current occupancy.
REQ-014 drop_cnt  output  8  samples lost to overflow, saturating.

Function
REQ-015 FSM states SHALL be IDLE, ARMED and TRACK.
- IDLE --en=1--> ARMED.
- ARMED --en=1--> TRACK, with an unconditional capture.
- TRACK --en=0--> IDLE.
- ARMED --en=0--> IDLE.
REQ-016 Capture condition: in ARMED with en=1, or in TRACK with en=1 and pc_in != last_pc.
REQ-017 A capture SHALL register {pc_in, result_in} as sampled at that rising edge; last_pc SHALL load pc_in on every capture, including dropped ones.
REQ-018 No capture SHALL occur in IDLE or while en=0.
REQ-019 The FIFO SHALL be first-word-fall-through. When the FIFO is empty, a captured entry SHALL appear on trc_data with trc_valid=1 exactly one cycle after the capture edge; there SHALL be no combinational bypass.
REQ-020 Pop SHALL occur when trc_valid && trc_ready. trc_data SHALL be stable while trc_valid=1 and trc_ready=0.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH. count SHALL update in the same edge as the push or pop.
REQ-022 Capture while full with no pop in the same cycle: the entry SHALL be discarded and drop_cnt SHALL increment, saturating at 255. FIFO contents SHALL be unchanged.
REQ-023 Capture and pop in the same cycle while full: both SHALL succeed, count SHALL be unchanged, and nothing is dropped.
REQ-024 Capture and pop in the same cycle with count=1: the old head SHALL leave, the new entry SHALL become head on the next cycle, and trc_valid SHALL stay 1.
REQ-025 Capture while empty with trc_ready=1: the entry SHALL NOT be popped in the capture cycle.
REQ-026 Pops SHALL continue in all FSM states, including IDLE.
REQ-027 trc_valid SHALL equal !empty.

Reset
REQ-028 While reset=0, all of the following SHALL hold:
- state=IDLE
- trc_valid=0, empty=1, full=0
- count=0, drop_cnt=0, trc_data=0
- pointers=0, last_pc=0
REQ-029 Reset asserted mid-operation SHALL discard all FIFO contents and drop_cnt.
REQ-030 After reset deasserts, the first capture SHALL require an IDLE->ARMED transition with en=1.

Verification
REQ-031 Enable with constant PC: reset release, en=1, pc_in=0x00 held, result_in=0x11.
- Required: exactly one entry 0x0011.
- trc_valid rises 2 cycles after en is first sampled high (ARMED, then capture).
REQ-032 PC step trace: pc_in steps 0x00,0x01,0x02 on successive cycles, result 0xA0,0xA1,0xA2, trc_ready=1.
- Required: entries 0x00A0, 0x01A1, 0x02A2 pop in order.
- count never exceeds 1.
REQ-033 Overflow with DEPTH=8: trc_ready=0 and 10 distinct PCs captured.
- Required: full=1, count=8, drop_cnt=2.
- The first 8 entries are retained; entries 9 and 10 are lost.
REQ-034 Full with simultaneous pop and capture: FIFO full, trc_ready=1 for one cycle during a capture.
- Required: count stays 8, drop_cnt is unchanged, and the new entry is at the tail.
REQ-035 Re-arm after en toggle: en 1->0->1 with pc_in held at 0x05.
- Required: a second 0x05xx entry is captured (ARMED forces capture despite an equal PC).
REQ-036 Reset mid-drain: reset=0 asynchronously with count=5.
- Required: trc_valid=0, count=0 and drop_cnt=0 immediately, without waiting for a clk edge.
